// File: rtl/stopwatch_pkg.sv
// Shared state encodings and display digit indices for the stopwatch controller.
package stopwatch_pkg;

  localparam logic [1:0] ST_RUN     = 2'b00;
  localparam logic [1:0] ST_PAUSED  = 2'b01;
  localparam logic [1:0] ST_ADJ_MIN = 2'b10;
  localparam logic [1:0] ST_ADJ_SEC = 2'b11;

  localparam int MT = 3;
  localparam int MO = 2;
  localparam int ST = 1;
  localparam int SO = 0;

  // Both adjust states share the top encoding bit.
  function automatic logic is_adj(input logic [1:0] s);
    return s[1];
  endfunction

endpackage

// File: rtl/sw_rise_det.sv
// Registered rising-edge detector; the history flop resets to 1 so a level
// already high when reset releases is not seen as an edge.
module sw_rise_det (
  input  logic clk,
  input  logic rst,
  input  logic din,
  output logic rise
);

  logic prev_q;
  logic prev_d;

  always_comb begin
    prev_d = din;
  end

  always_ff @(posedge clk) begin
    if (rst) prev_q <= 1'b1;
    else     prev_q <= prev_d;
  end

  assign rise = din & ~prev_q;

endmodule

// File: rtl/stopwatch_ctrl.sv
// Stopwatch mode controller: run/pause/adjust FSM, increment pulses and blink mask.
// Optional lap/display-hold feature enabled by defining STOPWATCH_LAP_EN.
module stopwatch_ctrl
  import stopwatch_pkg::*;
#(
  parameter bit START_PAUSED = 1'b0,
  parameter bit BLINK_EN     = 1'b1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       pause_btn,
  input  logic       adj_sw,
  input  logic       sel_sw,
  input  logic       tick_1hz,
  input  logic       tick_2hz,
  input  logic       tick_blink,
`ifdef STOPWATCH_LAP_EN
  input  logic       lap_btn,
`endif
  output logic       inc_sec,
  output logic       inc_min,
  output logic       carry_en,
  output logic [1:0] mode,
  output logic [3:0] blink_mask,
  output logic       disp_hold
);

  localparam logic [1:0] RST_STATE = START_PAUSED ? ST_PAUSED : ST_RUN;

  logic [1:0] state_q, state_d;
  logic [1:0] saved_q, saved_d;
  logic       inc_sec_q, inc_sec_d;
  logic       inc_min_q, inc_min_d;
  logic       carry_en_q, carry_en_d;
  logic       phase_q, phase_d;
  logic       pause_rise;

  sw_rise_det u_pause_det (
    .clk  (clk),
    .rst  (rst),
    .din  (pause_btn),
    .rise (pause_rise)
  );

  // Adjust switch outranks the pause button; pause edges seen while adjusting are dropped.
  always_comb begin
    state_d = state_q;
    saved_d = saved_q;
    case (state_q)
      ST_RUN, ST_PAUSED: begin
        if (adj_sw) begin
          saved_d = state_q;
          state_d = sel_sw ? ST_ADJ_SEC : ST_ADJ_MIN;
        end else if (pause_rise) begin
          state_d = (state_q == ST_RUN) ? ST_PAUSED : ST_RUN;
        end
      end
      default: begin
        if (!adj_sw) state_d = saved_q;
        else         state_d = sel_sw ? ST_ADJ_SEC : ST_ADJ_MIN;
      end
    endcase
  end

  // Pulses decode the state present when the tick arrives, not the next one.
  always_comb begin
    inc_sec_d  = ((state_q == ST_RUN) && tick_1hz) ||
                 ((state_q == ST_ADJ_SEC) && tick_2hz);
    inc_min_d  = (state_q == ST_ADJ_MIN) && tick_2hz;
    carry_en_d = (state_q == ST_RUN) && tick_1hz;
  end

  always_comb begin
    phase_d = phase_q;
    if (is_adj(state_d) && (state_d != state_q)) phase_d = 1'b0;
    else if (tick_blink)                         phase_d = ~phase_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= RST_STATE;
      saved_q    <= RST_STATE;
      inc_sec_q  <= 1'b0;
      inc_min_q  <= 1'b0;
      carry_en_q <= 1'b0;
      phase_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      saved_q    <= saved_d;
      inc_sec_q  <= inc_sec_d;
      inc_min_q  <= inc_min_d;
      carry_en_q <= carry_en_d;
      phase_q    <= phase_d;
    end
  end

  always_comb begin
    blink_mask = 4'b0000;
    if (BLINK_EN) begin
      case (state_q)
        ST_ADJ_MIN: begin
          blink_mask[MT] = phase_q;
          blink_mask[MO] = phase_q;
        end
        ST_ADJ_SEC: begin
          blink_mask[ST] = phase_q;
          blink_mask[SO] = phase_q;
        end
        default: blink_mask = 4'b0000;
      endcase
    end
  end

  assign inc_sec  = inc_sec_q;
  assign inc_min  = inc_min_q;
  assign carry_en = carry_en_q;
  assign mode     = state_q;

`ifdef STOPWATCH_LAP_EN
  logic lap_rise;
  logic disp_hold_q, disp_hold_d;

  sw_rise_det u_lap_det (
    .clk  (clk),
    .rst  (rst),
    .din  (lap_btn),
    .rise (lap_rise)
  );

  // Hold only makes sense while running; any exit from RUN releases it.
  always_comb begin
    disp_hold_d = disp_hold_q;
    if (state_d != ST_RUN)                     disp_hold_d = 1'b0;
    else if ((state_q == ST_RUN) && lap_rise)  disp_hold_d = ~disp_hold_q;
  end

  always_ff @(posedge clk) begin
    if (rst) disp_hold_q <= 1'b0;
    else     disp_hold_q <= disp_hold_d;
  end

  assign disp_hold = disp_hold_q;
`else
  assign disp_hold = 1'b0;
`endif

endmodule

// File: tb/tb_stopwatch_ctrl.sv
// Table-driven bench for stopwatch_ctrl plus hand-written reset/lap sequences.
// Lap checks are built only when STOPWATCH_LAP_EN is defined.
module tb_stopwatch_ctrl;

  typedef struct {
    logic       pause, adj, sel, t1, t2, tb;
    logic [1:0] mode;
    logic       isec, imin, carry;
    logic [3:0] mask;
  } vec_t;

  logic       clk = 1'b0;
  logic       rst, pause_btn, adj_sw, sel_sw, tick_1hz, tick_2hz, tick_blink;
  logic       inc_sec, inc_min, carry_en, disp_hold;
  logic [1:0] mode;
  logic [3:0] blink_mask;
  logic       inc_sec2, inc_min2, carry_en2, disp_hold2;
  logic [1:0] mode2;
  logic [3:0] blink_mask2;
`ifdef STOPWATCH_LAP_EN
  logic       lap_btn;
`endif

  int n_compared = 0;
  int n_failed   = 0;
  vec_t vecs[34];

  always #5 clk = ~clk;

  stopwatch_ctrl #(.START_PAUSED(1'b0), .BLINK_EN(1'b1)) u_dut (
    .clk(clk), .rst(rst), .pause_btn(pause_btn), .adj_sw(adj_sw), .sel_sw(sel_sw),
    .tick_1hz(tick_1hz), .tick_2hz(tick_2hz), .tick_blink(tick_blink),
`ifdef STOPWATCH_LAP_EN
    .lap_btn(lap_btn),
`endif
    .inc_sec(inc_sec), .inc_min(inc_min), .carry_en(carry_en), .mode(mode),
    .blink_mask(blink_mask), .disp_hold(disp_hold)
  );

  // Second instance: starts paused with blinking disabled.
  stopwatch_ctrl #(.START_PAUSED(1'b1), .BLINK_EN(1'b0)) u_dut2 (
    .clk(clk), .rst(rst), .pause_btn(pause_btn), .adj_sw(adj_sw), .sel_sw(sel_sw),
    .tick_1hz(tick_1hz), .tick_2hz(tick_2hz), .tick_blink(tick_blink),
`ifdef STOPWATCH_LAP_EN
    .lap_btn(lap_btn),
`endif
    .inc_sec(inc_sec2), .inc_min(inc_min2), .carry_en(carry_en2), .mode(mode2),
    .blink_mask(blink_mask2), .disp_hold(disp_hold2)
  );

  function automatic vec_t mk(input logic [5:0] in, input logic [1:0] m,
                              input logic [2:0] pulses, input logic [3:0] mask);
    vec_t v;
    {v.pause, v.adj, v.sel, v.t1, v.t2, v.tb} = in;
    v.mode = m;
    {v.isec, v.imin, v.carry} = pulses;
    v.mask = mask;
    return v;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string name, input logic [3:0] act, input logic [3:0] exp);
    n_compared++;
    if (act !== exp) begin
      n_failed++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic applyStimulus(input vec_t v);
    pause_btn  = v.pause;
    adj_sw     = v.adj;
    sel_sw     = v.sel;
    tick_1hz   = v.t1;
    tick_2hz   = v.t2;
    tick_blink = v.tb;
    tick();
  endtask

  task automatic clearInputs();
    pause_btn = 0; adj_sw = 0; sel_sw = 0;
    tick_1hz = 0; tick_2hz = 0; tick_blink = 0;
  endtask

  initial begin
    // inputs {pause,adj,sel,t1,t2,tb}, mode, {inc_sec,inc_min,carry_en}, blink_mask
    vecs[0]  = mk(6'b000100, 2'b00, 3'b101, 4'h0);
    vecs[1]  = mk(6'b000000, 2'b00, 3'b000, 4'h0);
    vecs[2]  = mk(6'b000100, 2'b00, 3'b101, 4'h0);
    vecs[3]  = mk(6'b000100, 2'b00, 3'b101, 4'h0);
    vecs[4]  = mk(6'b000000, 2'b00, 3'b000, 4'h0);
    vecs[5]  = mk(6'b100000, 2'b01, 3'b000, 4'h0);
    vecs[6]  = mk(6'b100100, 2'b01, 3'b000, 4'h0);
    vecs[7]  = mk(6'b000100, 2'b01, 3'b000, 4'h0);
    vecs[8]  = mk(6'b100000, 2'b00, 3'b000, 4'h0);
    vecs[9]  = mk(6'b000000, 2'b00, 3'b000, 4'h0);
    vecs[10] = mk(6'b100000, 2'b01, 3'b000, 4'h0);
    vecs[11] = mk(6'b011000, 2'b11, 3'b000, 4'h0);
    vecs[12] = mk(6'b011010, 2'b11, 3'b100, 4'h0);
    vecs[13] = mk(6'b011010, 2'b11, 3'b100, 4'h0);
    vecs[14] = mk(6'b011010, 2'b11, 3'b100, 4'h0);
    vecs[15] = mk(6'b011010, 2'b11, 3'b100, 4'h0);
    vecs[16] = mk(6'b011100, 2'b11, 3'b000, 4'h0);
    vecs[17] = mk(6'b010000, 2'b10, 3'b000, 4'h0);
    vecs[18] = mk(6'b010001, 2'b10, 3'b000, 4'hC);
    vecs[19] = mk(6'b010010, 2'b10, 3'b010, 4'hC);
    vecs[20] = mk(6'b010001, 2'b10, 3'b000, 4'h0);
    vecs[21] = mk(6'b010001, 2'b10, 3'b000, 4'hC);
    vecs[22] = mk(6'b110000, 2'b10, 3'b000, 4'hC);
    vecs[23] = mk(6'b100000, 2'b01, 3'b000, 4'h0);
    vecs[24] = mk(6'b000010, 2'b01, 3'b000, 4'h0);
    vecs[25] = mk(6'b100100, 2'b00, 3'b000, 4'h0);
    vecs[26] = mk(6'b000010, 2'b00, 3'b000, 4'h0);
    vecs[27] = mk(6'b100100, 2'b01, 3'b101, 4'h0);
    vecs[28] = mk(6'b000000, 2'b01, 3'b000, 4'h0);
    vecs[29] = mk(6'b110000, 2'b10, 3'b000, 4'h0);
    vecs[30] = mk(6'b000000, 2'b01, 3'b000, 4'h0);
    vecs[31] = mk(6'b011010, 2'b11, 3'b000, 4'h0);
    vecs[32] = mk(6'b011010, 2'b11, 3'b100, 4'h0);
    vecs[33] = mk(6'b000000, 2'b01, 3'b000, 4'h0);

    clearInputs();
    rst = 1;
`ifdef STOPWATCH_LAP_EN
    lap_btn = 0;
`endif
    tick();
    tick();
    checkOutput("rst.mode", {2'b00, mode}, 4'h0);
    checkOutput("rst.inc_sec", {3'b000, inc_sec}, 4'h0);
    checkOutput("rst.carry", {3'b000, carry_en}, 4'h0);
    checkOutput("rst.mask", blink_mask, 4'h0);
    checkOutput("rst.hold", {3'b000, disp_hold}, 4'h0);
    checkOutput("rst.mode2", {2'b00, mode2}, 4'h1);
    rst = 0;

    for (int i = 0; i < 34; i++) begin
      applyStimulus(vecs[i]);
      checkOutput($sformatf("v%0d.mode", i), {2'b00, mode}, {2'b00, vecs[i].mode});
      checkOutput($sformatf("v%0d.inc_sec", i), {3'b000, inc_sec}, {3'b000, vecs[i].isec});
      checkOutput($sformatf("v%0d.inc_min", i), {3'b000, inc_min}, {3'b000, vecs[i].imin});
      checkOutput($sformatf("v%0d.carry", i), {3'b000, carry_en}, {3'b000, vecs[i].carry});
      checkOutput($sformatf("v%0d.mask", i), blink_mask, vecs[i].mask);
      if (vecs[i].mask != 4'h0)
        checkOutput($sformatf("v%0d.mask2", i), blink_mask2, 4'h0);
    end

    // Reset asserted mid-adjust with a tick pending overrides everything.
    clearInputs();
    adj_sw = 1; sel_sw = 1;
    tick();
    checkOutput("ra.enter", {2'b00, mode}, 4'h3);
    tick_2hz = 1; rst = 1;
    tick();
    checkOutput("ra.mode", {2'b00, mode}, 4'h0);
    checkOutput("ra.inc_sec", {3'b000, inc_sec}, 4'h0);
    checkOutput("ra.mode2", {2'b00, mode2}, 4'h1);
    rst = 0; clearInputs();
    tick();
    checkOutput("ra.after", {2'b00, mode}, 4'h0);
    tick_1hz = 1;
    tick();
    checkOutput("ra.run_inc", {3'b000, inc_sec}, 4'h1);
    checkOutput("ra.run_carry", {3'b000, carry_en}, 4'h1);
    tick_1hz = 0;

    // Pause held through reset release must not toggle.
    pause_btn = 1; rst = 1;
    tick();
    tick();
    rst = 0;
    tick();
    checkOutput("hold.mode0", {2'b00, mode}, 4'h0);
    tick();
    checkOutput("hold.mode1", {2'b00, mode}, 4'h0);
    checkOutput("hold.mode2", {2'b00, mode2}, 4'h1);
    pause_btn = 0;
    tick();
    pause_btn = 1;
    tick();
    checkOutput("hold.edge", {2'b00, mode}, 4'h1);

`ifdef STOPWATCH_LAP_EN
    pause_btn = 0;
    tick();
    pause_btn = 1;
    tick();
    checkOutput("lap.run", {2'b00, mode}, 4'h0);
    pause_btn = 0; lap_btn = 1; tick_1hz = 1;
    tick();
    checkOutput("lap.hold", {3'b000, disp_hold}, 4'h1);
    checkOutput("lap.inc0", {3'b000, inc_sec}, 4'h1);
    tick();
    checkOutput("lap.hold1", {3'b000, disp_hold}, 4'h1);
    checkOutput("lap.inc1", {3'b000, inc_sec}, 4'h1);
    lap_btn = 0; tick_1hz = 0; pause_btn = 1;
    tick();
    checkOutput("lap.pmode", {2'b00, mode}, 4'h1);
    checkOutput("lap.release", {3'b000, disp_hold}, 4'h0);
`else
    checkOutput("nolap.hold", {3'b000, disp_hold}, 4'h0);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_failed);
    $finish;
  end

endmodule
